// File: rtl/decoder_pkg.sv
// Shared types and SRAM memory map for the image decompressor.
package decoder_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_UART     = 3'd1,
      S_M2_START = 3'd2,
      S_M2_RUN   = 3'd3,
      S_M1_START = 3'd4,
      S_M1_RUN   = 3'd5,
      S_DISPLAY  = 3'd6,
      S_ERROR    = 3'd7
   } seq_state_t;

   typedef enum logic [2:0] {
      OWN_NONE = 3'd0,
      OWN_UART = 3'd1,
      OWN_M2   = 3'd2,
      OWN_M1   = 3'd3,
      OWN_VGA  = 3'd4
   } owner_t;

   localparam logic [17:0] Y_OFFSET   = 18'd0;
   localparam logic [17:0] U_OFFSET   = 18'd38400;
   localparam logic [17:0] V_OFFSET   = 18'd57600;
   localparam logic [17:0] RGB_OFFSET = 18'd146944;

   // Start states are the write-free gap cycles between requesters.
   function automatic owner_t state_owner(input seq_state_t s);
      case (s)
         S_UART:    return OWN_UART;
         S_M2_RUN:  return OWN_M2;
         S_M1_RUN:  return OWN_M1;
         S_DISPLAY: return OWN_VGA;
         default:   return OWN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sram_owner_mux.sv
// Combinational select of the single SRAM port by the registered owner.
module sram_owner_mux
   import decoder_pkg::*;
(
   input  owner_t      owner,
   input  logic [17:0] uart_address,
   input  logic        uart_we_n,
   input  logic [15:0] uart_write_data,
   input  logic [17:0] m2_address,
   input  logic        m2_we_n,
   input  logic [15:0] m2_write_data,
   input  logic [17:0] m1_address,
   input  logic        m1_we_n,
   input  logic [15:0] m1_write_data,
   input  logic [17:0] vga_address,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n
);

   always_comb begin
      SRAM_address    = 18'd0;
      SRAM_write_data = 16'd0;
      SRAM_we_n       = 1'b1;
      case (owner)
         OWN_UART: begin
            SRAM_address    = uart_address;
            SRAM_write_data = uart_write_data;
            SRAM_we_n       = uart_we_n;
         end
         OWN_M2: begin
            SRAM_address    = m2_address;
            SRAM_write_data = m2_write_data;
            SRAM_we_n       = m2_we_n;
         end
         OWN_M1: begin
            SRAM_address    = m1_address;
            SRAM_write_data = m1_write_data;
            SRAM_we_n       = m1_we_n;
         end
         OWN_VGA: SRAM_address = vga_address;
         default: ;
      endcase
   end

endmodule

// File: rtl/decoder_sequencer.sv
// Stage sequencer and SRAM bus owner: UART -> M2 -> M1 -> display.
// Optional per-stage watchdog enabled by defining SEQ_TIMEOUT_EN.
//
// state      | meaning
// S_IDLE     | waiting for go, bus idle
// S_UART     | UART loader owns SRAM, wait uart_done edge
// S_M2_START | gap cycle, m2_start pulse
// S_M2_RUN   | milestone2 owns SRAM, wait m2_done edge
// S_M1_START | gap cycle, m1_start pulse
// S_M1_RUN   | milestone1 owns SRAM, wait m1_done edge
// S_DISPLAY  | VGA reads SRAM, go starts a new image
// S_ERROR    | watchdog expired, held until reset
module decoder_sequencer
   import decoder_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000,
   parameter int          STAGE_W        = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               go,
   input  logic               uart_done,
   input  logic [17:0]        uart_address,
   input  logic               uart_we_n,
   input  logic [15:0]        uart_write_data,
   output logic               m2_start,
   input  logic               m2_done,
   input  logic [17:0]        m2_address,
   input  logic               m2_we_n,
   input  logic [15:0]        m2_write_data,
   output logic               m1_start,
   input  logic               m1_done,
   input  logic [17:0]        m1_address,
   input  logic               m1_we_n,
   input  logic [15:0]        m1_write_data,
   input  logic [17:0]        vga_address,
   output logic [17:0]        SRAM_address,
   output logic [15:0]        SRAM_write_data,
   output logic               SRAM_we_n,
   output logic               busy,
   output logic [STAGE_W-1:0] stage,
   output logic               error
);

   seq_state_t state_q, state_d;
   owner_t     owner_q;
   logic       uart_done_q, m2_done_q, m1_done_q;
   logic       uart_edge, m2_edge, m1_edge;
   logic       timeout;

   assign uart_edge = uart_done & ~uart_done_q;
   assign m2_edge   = m2_done & ~m2_done_q;
   assign m1_edge   = m1_done & ~m1_done_q;

   // Owner is registered from the next state so the mux adds no latency.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_NONE;
         uart_done_q <= 1'b0;
         m2_done_q   <= 1'b0;
         m1_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= state_owner(state_d);
         uart_done_q <= uart_done;
         m2_done_q   <= m2_done;
         m1_done_q   <= m1_done;
      end
   end

`ifdef SEQ_TIMEOUT_EN
   logic [23:0] wd_q;
   logic        error_q;
   logic        watched;

   assign watched = (state_q == S_UART) || (state_q == S_M2_RUN) || (state_q == S_M1_RUN);
   assign timeout = watched && (wd_q == TIMEOUT_CYCLES - 24'd1);
   assign error   = error_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         wd_q    <= 24'd0;
         error_q <= 1'b0;
      end else begin
         if (state_d != state_q)
            wd_q <= 24'd0;
         else if (watched)
            wd_q <= wd_q + 24'd1;
         if (state_d == S_ERROR)
            error_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign error   = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      m2_start = 1'b0;
      m1_start = 1'b0;
      case (state_q)
         S_IDLE:     if (go) state_d = S_UART;
         S_UART: begin
            if (uart_edge)    state_d = S_M2_START;
            else if (timeout) state_d = S_ERROR;
         end
         S_M2_START: begin
            m2_start = 1'b1;
            state_d  = S_M2_RUN;
         end
         S_M2_RUN: begin
            if (m2_edge)      state_d = S_M1_START;
            else if (timeout) state_d = S_ERROR;
         end
         S_M1_START: begin
            m1_start = 1'b1;
            state_d  = S_M1_RUN;
         end
         S_M1_RUN: begin
            if (m1_edge)      state_d = S_DISPLAY;
            else if (timeout) state_d = S_ERROR;
         end
         S_DISPLAY:  if (go) state_d = S_UART;
         S_ERROR:    state_d = S_ERROR;
         default:    state_d = S_IDLE;
      endcase
   end

   assign busy  = (state_q != S_IDLE) && (state_q != S_DISPLAY);
   assign stage = STAGE_W'(state_q);

   // Memory map and watchdog limit are consumed by the stage blocks too.
   logic unused_map;
   assign unused_map = ^{TIMEOUT_CYCLES, Y_OFFSET, U_OFFSET, V_OFFSET, RGB_OFFSET};

   sram_owner_mux u_mux (
      .owner           (owner_q),
      .uart_address    (uart_address),
      .uart_we_n       (uart_we_n),
      .uart_write_data (uart_write_data),
      .m2_address      (m2_address),
      .m2_we_n         (m2_we_n),
      .m2_write_data   (m2_write_data),
      .m1_address      (m1_address),
      .m1_we_n         (m1_we_n),
      .m1_write_data   (m1_write_data),
      .vga_address     (vga_address),
      .SRAM_address    (SRAM_address),
      .SRAM_write_data (SRAM_write_data),
      .SRAM_we_n       (SRAM_we_n)
   );

endmodule
